// File: rtl/rv32imf_div_ctrl.sv
// Sequencing controller for the iterative integer divider: accepts one DIV/REM
// request, normalises the divisor, runs the divider and returns the tagged result.
module rv32imf_div_ctrl #(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RI,
  input  logic                   ReqVld_SI,
  output logic                   ReqRdy_SO,
  input  logic [1:0]             ReqOp_SI,
  input  logic [C_WIDTH-1:0]     ReqA_DI,
  input  logic [C_WIDTH-1:0]     ReqB_DI,
  input  logic [4:0]             ReqTag_DI,
  input  logic                   Flush_SI,
  output logic [C_WIDTH-1:0]     DivOpA_DO,
  output logic [C_WIDTH-1:0]     DivOpB_DO,
  output logic [C_LOG_WIDTH-1:0] DivOpBShift_DO,
  output logic                   DivOpBIsZero_SO,
  output logic                   DivOpBSign_SO,
  output logic [1:0]             DivOpCode_SO,
  output logic                   DivInVld_SO,
  output logic                   DivOutRdy_SO,
  input  logic                   DivOutVld_SI,
  input  logic [C_WIDTH-1:0]     DivRes_DI,
  output logic                   RspVld_SO,
  input  logic                   RspRdy_SI,
  output logic [C_WIDTH-1:0]     RspRes_DO,
  output logic [4:0]             RspTag_DO
);

  localparam logic [2:0] S_DRAIN = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_PREP  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [C_WIDTH-1:0]     a_q, b_q;
  logic [1:0]             op_q;
  logic [4:0]             tag_q;
  logic [C_WIDTH-1:0]     div_a_q, div_b_q;
  logic [C_LOG_WIDTH-1:0] div_shift_q;
  logic                   div_zero_q, div_sign_q;
  logic [1:0]             div_code_q;
  logic [C_WIDTH-1:0]     rsp_res_q;
  logic [4:0]             rsp_tag_q;

  logic                   req_fire;
  logic [C_LOG_WIDTH-1:0] prep_shift;

  // Normalisation distance: unsigned strips leading zeros, signed keeps one
  // sign bit; zero and all-ones divisors saturate at the maximum shift.
  function automatic logic [C_LOG_WIDTH-1:0] calc_shift(input logic [C_WIDTH-1:0] b,
                                                        input logic sgn);
    logic ref_bit;
    logic done;
    int   cnt;
    ref_bit = sgn & b[C_WIDTH-1];
    done    = 1'b0;
    cnt     = 0;
    for (int i = C_WIDTH - 1; i >= 0; i--) begin
      if (!done) begin
        if (b[i] == ref_bit) cnt = cnt + 1;
        else done = 1'b1;
      end
    end
    if (sgn) cnt = cnt - 1;
    if ((b == '0) || (b == '1)) cnt = C_WIDTH - 1;
    return cnt[C_LOG_WIDTH-1:0];
  endfunction

  assign prep_shift = calc_shift(b_q, op_q[0]);

  assign ReqRdy_SO    = ~Rst_RI & ~Flush_SI & (state_q == S_IDLE);
  assign DivInVld_SO  = ~Rst_RI & ~Flush_SI & (state_q == S_ISSUE);
  assign DivOutRdy_SO = ~Rst_RI & ((state_q == S_WAIT) | (state_q == S_DRAIN));
  assign RspVld_SO    = ~Rst_RI & ~Flush_SI & (state_q == S_RESP);
  assign req_fire     = ReqVld_SI & ReqRdy_SO;

  assign DivOpA_DO       = Rst_RI ? '0 : div_a_q;
  assign DivOpB_DO       = Rst_RI ? '0 : div_b_q;
  assign DivOpBShift_DO  = Rst_RI ? '0 : div_shift_q;
  assign DivOpBIsZero_SO = ~Rst_RI & div_zero_q;
  assign DivOpBSign_SO   = ~Rst_RI & div_sign_q;
  assign DivOpCode_SO    = Rst_RI ? '0 : div_code_q;
  assign RspRes_DO       = Rst_RI ? '0 : rsp_res_q;
  assign RspTag_DO       = Rst_RI ? '0 : rsp_tag_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DRAIN: if (DivOutVld_SI) state_d = S_IDLE;
      S_IDLE:  if (req_fire) state_d = S_PREP;
      S_PREP:  state_d = Flush_SI ? S_IDLE : S_ISSUE;
      S_ISSUE: state_d = Flush_SI ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (Flush_SI) state_d = S_DRAIN;
        else if (DivOutVld_SI) state_d = S_RESP;
      end
      S_RESP:  if (Flush_SI || RspRdy_SI) state_d = S_IDLE;
      default: state_d = S_DRAIN;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q     <= S_DRAIN;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      tag_q       <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      div_shift_q <= '0;
      div_zero_q  <= 1'b0;
      div_sign_q  <= 1'b0;
      div_code_q  <= '0;
      rsp_res_q   <= '0;
      rsp_tag_q   <= '0;
    end else begin
      state_q <= state_d;
      // accept stage
      if (req_fire) begin
        a_q   <= ReqA_DI;
        b_q   <= ReqB_DI;
        op_q  <= ReqOp_SI;
        tag_q <= ReqTag_DI;
      end
      // preprocessing stage: operands held from here until the divider returns
      if (state_q == S_PREP) begin
        div_a_q     <= a_q;
        div_b_q     <= b_q << prep_shift;
        div_shift_q <= prep_shift;
        div_zero_q  <= (b_q == '0);
        div_sign_q  <= op_q[0] & b_q[C_WIDTH-1];
        div_code_q  <= op_q;
      end
      // result capture stage
      if ((state_q == S_WAIT) && DivOutVld_SI && !Flush_SI) begin
        rsp_res_q <= DivRes_DI;
        rsp_tag_q <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_rv32imf_div_ctrl.sv
// Self-checking bench for rv32imf_div_ctrl with a behavioural iterative divider
// whose IDLE and FINISH states both present DivOutVld.
module tb_rv32imf_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_tag = '0;
  logic        flush = 1'b0;
  logic [31:0] div_op_a, div_op_b;
  logic [5:0]  div_op_b_shift;
  logic        div_op_b_is_zero, div_op_b_sign;
  logic [1:0]  div_op_code;
  logic        div_in_vld, div_out_rdy, div_out_vld;
  logic [31:0] div_res;
  logic        rsp_vld;
  logic        rsp_rdy = 1'b0;
  logic [31:0] rsp_res;
  logic [4:0]  rsp_tag;

  int vectors = 0;
  int miscompares = 0;
  logic [36:0] scb[$];
  logic [31:0] cur_b = '0;

  always #5 clk = ~clk;

  rv32imf_div_ctrl #(.C_WIDTH(32), .C_LOG_WIDTH(6)) dut (
    .Clk_CI(clk), .Rst_RI(rst),
    .ReqVld_SI(req_vld), .ReqRdy_SO(req_rdy), .ReqOp_SI(req_op),
    .ReqA_DI(req_a), .ReqB_DI(req_b), .ReqTag_DI(req_tag), .Flush_SI(flush),
    .DivOpA_DO(div_op_a), .DivOpB_DO(div_op_b), .DivOpBShift_DO(div_op_b_shift),
    .DivOpBIsZero_SO(div_op_b_is_zero), .DivOpBSign_SO(div_op_b_sign),
    .DivOpCode_SO(div_op_code), .DivInVld_SO(div_in_vld), .DivOutRdy_SO(div_out_rdy),
    .DivOutVld_SI(div_out_vld), .DivRes_DI(div_res),
    .RspVld_SO(rsp_vld), .RspRdy_SI(rsp_rdy), .RspRes_DO(rsp_res), .RspTag_DO(rsp_tag)
  );

  function automatic logic [31:0] rv_div(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [31:0] sa, sd;
    logic ovf;
    sa  = a;
    sd  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sd));
      2'b10:   return (b == 0) ? a : a % b;
      default: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sd));
    endcase
  endfunction

  function automatic int ref_shift(input logic [31:0] b, input logic sgn);
    if (b == 32'h0 || b == 32'hFFFF_FFFF) return 31;
    if (!sgn) begin
      for (int i = 31; i >= 0; i--) if (b[i]) return 31 - i;
    end else begin
      for (int i = 30; i >= 0; i--) if (b[i] != b[31]) return 30 - i;
    end
    return 31;
  endfunction

  // Divider model: busy for Shift+1 cycles after issue, then FINISH until read.
  logic [1:0]  dstate = 2'd0;
  int          dcnt = 0;
  logic [31:0] dres = '0;
  assign div_out_vld = (dstate != 2'd1);
  assign div_res     = dres;
  always @(posedge clk) begin
    if ((dstate != 2'd1) && div_in_vld) begin
      dres   <= rv_div(div_op_code, div_op_a, cur_b);
      dcnt   <= int'(div_op_b_shift) + 1;
      dstate <= 2'd1;
    end else if (dstate == 2'd1) begin
      if (dcnt == 1) dstate <= 2'd2;
      else dcnt <= dcnt - 1;
    end else if ((dstate == 2'd2) && div_out_rdy) begin
      dstate <= 2'd0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk); #1;
    vectors++;
    if ({req_rdy, rsp_vld, div_in_vld, div_out_rdy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 0000", {req_rdy, rsp_vld, div_in_vld, div_out_rdy});
    end
    vectors++;
    if ({div_op_a, div_op_b, div_op_b_shift, div_op_b_is_zero, div_op_b_sign, div_op_code,
         rsp_res, rsp_tag} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got a=%h b=%h sh=%0d res=%h tag=%0d want all zero",
               div_op_a, div_op_b, div_op_b_shift, rsp_res, rsp_tag);
    end
    @(negedge clk); rst = 1'b0; #1;
    vectors++;
    if ({req_rdy, div_out_rdy} !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_drain got rdy/outrdy=%b want 01", {req_rdy, div_out_rdy});
    end
    @(negedge clk); #1;
    vectors++;
    if ({req_rdy, div_out_rdy} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_idle got rdy/outrdy=%b want 10", {req_rdy, div_out_rdy});
    end
  endtask

  // Full transaction; response held for 'stall' cycles (>=1) before the handshake.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp_res, input int stall,
                       input bit flush_resp);
    int sh, lat;
    logic [31:0] ob;
    logic [36:0] e;
    sh = ref_shift(b, op[0]);
    ob = b << sh;
    cur_b = b;
    scb.push_back({tag, exp_res});
    @(negedge clk);
    req_vld = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    #1;
    vectors++;
    if (req_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_rdy got %b want 1", req_rdy);
    end
    @(negedge clk);
    req_vld = 1'b0; req_a = $urandom; req_b = $urandom; req_tag = 5'($urandom);
    #1;
    vectors++;
    if ({req_rdy, div_in_vld, div_out_rdy} !== 3'b000) begin
      miscompares++;
      $display("FAIL prep_ctrl got %b want 000", {req_rdy, div_in_vld, div_out_rdy});
    end
    @(negedge clk); #1;
    vectors++;
    if ({div_in_vld, div_op_a, div_op_b, div_op_b_shift, div_op_b_is_zero, div_op_b_sign,
         div_op_code} !== {1'b1, a, ob, 6'(sh), (b == 0), op[0] & b[31], op}) begin
      miscompares++;
      $display("FAIL issue_ops got vld=%b a=%h b=%h sh=%0d z=%b s=%b op=%0d want vld=1 a=%h b=%h sh=%0d z=%b s=%b op=%0d",
               div_in_vld, div_op_a, div_op_b, div_op_b_shift, div_op_b_is_zero, div_op_b_sign,
               div_op_code, a, ob, sh, (b == 0), op[0] & b[31], op);
    end
    @(negedge clk); #1;
    vectors++;
    if ({div_in_vld, div_out_rdy, div_op_b} !== {2'b01, ob}) begin
      miscompares++;
      $display("FAIL wait_ctrl got vld/rdy=%b b=%h want 01 b=%h", {div_in_vld, div_out_rdy},
               div_op_b, ob);
    end
    lat = 3;
    while (!rsp_vld && lat < 100) begin
      @(negedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat !== sh + 5) begin
      miscompares++;
      $display("FAIL latency got %0d want %0d", lat, sh + 5);
    end
    e = scb.pop_front();
    if (!rsp_vld) return;
    for (int k = 0; k < stall; k++) begin
      if (k > 0) begin
        @(negedge clk); #1;
      end
      vectors++;
      if ({rsp_vld, rsp_tag, rsp_res} !== {1'b1, e}) begin
        miscompares++;
        $display("FAIL resp_hold%0d got vld=%b tag=%0d res=%h want vld=1 tag=%0d res=%h",
                 k, rsp_vld, rsp_tag, rsp_res, e[36:32], e[31:0]);
      end
    end
    @(negedge clk);
    if (flush_resp) flush = 1'b1;
    else rsp_rdy = 1'b1;
    @(negedge clk);
    flush = 1'b0; rsp_rdy = 1'b0;
    #1;
    vectors++;
    if ({rsp_vld, req_rdy} !== 2'b01) begin
      miscompares++;
      $display("FAIL resp_done got vld/rdy=%b want 01", {rsp_vld, req_rdy});
    end
  endtask

  // Abort a DIVU 100/7 in WAIT via flush or a reset pulse; expect DRAIN until divider FINISH.
  task automatic abort_in_wait(input bit use_rst, input int abort_cyc);
    int cyc;
    bit seen_rsp;
    cur_b = 32'd7;
    @(negedge clk);
    req_vld = 1'b1; req_op = 2'b00; req_a = 32'd100; req_b = 32'd7; req_tag = 5'd9;
    for (cyc = 1; cyc <= abort_cyc; cyc++) begin
      @(negedge clk);
      req_vld = 1'b0;
    end
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    #1;
    if (use_rst) begin
      vectors++;
      if ({req_rdy, rsp_vld, div_in_vld, div_out_rdy, div_op_a, div_op_b} !== '0) begin
        miscompares++;
        $display("FAIL abort_in_reset got rdy=%b outrdy=%b a=%h b=%h want all zero",
                 req_rdy, div_out_rdy, div_op_a, div_op_b);
      end
    end
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    #1;
    vectors++;
    if ({req_rdy, div_out_rdy, rsp_vld} !== 3'b010) begin
      miscompares++;
      $display("FAIL abort_drain got rdy/outrdy/vld=%b want 010", {req_rdy, div_out_rdy, rsp_vld});
    end
    cyc = abort_cyc + 1;
    seen_rsp = 1'b0;
    while (!req_rdy && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
      if (rsp_vld) seen_rsp = 1'b1;
    end
    vectors++;
    if (cyc !== 34) begin
      miscompares++;
      $display("FAIL abort_idle_cycle got %0d want 34", cyc);
    end
    vectors++;
    if (seen_rsp !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_rsp got %b want 0", seen_rsp);
    end
  endtask

  task automatic test_flush_early(input int at_cyc);
    cur_b = 32'd5;
    @(negedge clk);
    req_vld = 1'b1; req_op = 2'b01; req_a = 32'd50; req_b = 32'd5; req_tag = 5'd4;
    for (int c = 1; c <= at_cyc; c++) begin
      @(negedge clk);
      req_vld = 1'b0;
    end
    flush = 1'b1;
    #1;
    vectors++;
    if ({req_rdy, div_in_vld, div_out_rdy} !== 3'b000) begin
      miscompares++;
      $display("FAIL flush_early%0d_ctrl got %b want 000", at_cyc, {req_rdy, div_in_vld, div_out_rdy});
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    vectors++;
    if ({req_rdy, div_in_vld, div_out_rdy, dstate} !== 5'b10000) begin
      miscompares++;
      $display("FAIL flush_early%0d_idle got rdy/invld/outrdy=%b div_state=%0d want 100 state 0",
               at_cyc, {req_rdy, div_in_vld, div_out_rdy}, dstate);
    end
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    req_vld = 1'b1; flush = 1'b1; req_a = 32'd1; req_b = 32'd1;
    #1;
    vectors++;
    if (req_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle_rdy got %b want 0", req_rdy);
    end
    @(negedge clk);
    req_vld = 1'b0; flush = 1'b0;
    #1;
    vectors++;
    if ({req_rdy, div_in_vld} !== 2'b10) begin
      miscompares++;
      $display("FAIL flush_idle_noaccept got rdy/invld=%b want 10", {req_rdy, div_in_vld});
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(1, 1000);
        2: b = 32'hFFFF_FFFF;
        default: b = 32'h8000_0000 | $urandom_range(0, 255);
      endcase
      do_op(op, a, b, 5'(i + 16), rv_div(op, a, b), 1 + (i % 2), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    do_op(2'b00, 32'd100, 32'd7, 5'd3, 32'd14, 1, 1'b0);
    do_op(2'b01, 32'hFFFF_FF9C, 32'd7, 5'd5, 32'hFFFF_FFF2, 1, 1'b0);
    do_op(2'b10, 32'h1234, 32'd0, 5'd7, 32'h1234, 1, 1'b0);
    do_op(2'b11, 32'd77, 32'hFFFF_FFF9, 5'd11, 32'd0, 3, 1'b0);
    abort_in_wait(1'b0, 6);
    do_op(2'b00, 32'd1000, 32'd10, 5'd12, 32'd100, 1, 1'b1);
    test_flush_early(1);
    test_flush_early(2);
    test_flush_idle();
    abort_in_wait(1'b1, 5);
    do_op(2'b00, 32'd100, 32'd7, 5'd3, 32'd14, 1, 1'b0);
    test_random();
    vectors++;
    if (scb.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty got %0d entries want 0", scb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv32imf_div_ctrl.md
RV32IMF_DIV_CTRL -- requirements
Module: rv32imf_div_ctrl

Interface
REQ-001 SHALL have parameter C_WIDTH, default 32, datapath width.
REQ-002 SHALL have parameter C_LOG_WIDTH, default 6, shift/count width.
REQ-003 SHALL have port Clk_CI  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port Rst_RI  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports ReqVld_SI in 1 / ReqRdy_SO out 1  request handshake.
REQ-006 SHALL have ReqOp_SI in 2: bit0 signed, bit1 remainder (00 DIVU, 01 DIV, 10 REMU, 11 REM).
REQ-007 SHALL have ReqA_DI in C_WIDTH dividend; ReqB_DI in C_WIDTH divisor; ReqTag_DI in 5 destination tag.
REQ-008 SHALL have Flush_SI in 1  cancels the in-flight operation.
REQ-009 SHALL have divider-side outputs DivOpA_DO C_WIDTH, DivOpB_DO C_WIDTH, DivOpBShift_DO C_LOG_WIDTH, DivOpBIsZero_SO 1, DivOpBSign_SO 1, DivOpCode_SO 2, DivInVld_SO 1, DivOutRdy_SO 1.
REQ-010 SHALL have divider-side inputs DivOutVld_SI 1, DivRes_DI C_WIDTH.
REQ-011 SHALL have ports RspVld_SO out 1, RspRdy_SI in 1, RspRes_DO out C_WIDTH, RspTag_DO out 5.

Function
REQ-012 SHALL use FSM states DRAIN, IDLE, PREP, ISSUE, WAIT, RESP.
REQ-013 SHALL drive ReqRdy_SO=1 only in IDLE with Rst_RI=0; accept on ReqVld_SI&ReqRdy_SO; latch A, B, op, tag; go to PREP.
REQ-014 PREP SHALL register the preprocessing results: DivOpA=A; DivOpCode=op; DivOpBIsZero=(B==0); DivOpBSign=op[0]&B[31].
REQ-015 PREP shift: unsigned Shift=leading zeros of B; signed Shift=(count of leading bits equal to B[31])-1; B==0 or B==all-ones forces Shift=31; DivOpB=B<<Shift, truncated to C_WIDTH.
REQ-016 ISSUE SHALL assert DivInVld_SO for exactly one cycle; next state WAIT; divider operand outputs stay stable from PREP until WAIT exits.
REQ-017 WAIT SHALL assert DivOutRdy_SO; on DivOutVld_SI=1, capture DivRes_DI into the response register unmodified; go to RESP.
REQ-018 RESP SHALL hold RspVld_SO=1 with RspRes_DO and RspTag_DO stable until RspRdy_SI=1; then go to IDLE.
REQ-019 Latency from request accept to first RspVld_SO: Shift+5 cycles.
REQ-020 Flush_SI in PREP or ISSUE SHALL return to IDLE with DivInVld_SO=0 that cycle; the divider is not started.
REQ-021 Flush_SI in WAIT SHALL go to DRAIN; the result is discarded and no RspVld_SO is produced.
REQ-022 Flush_SI in RESP SHALL drop the response and go to IDLE.
REQ-023 Flush_SI in IDLE with ReqVld_SI=1 SHALL take priority: no accept.
REQ-024 DRAIN SHALL assert DivOutRdy_SO and go to IDLE on the first cycle DivOutVld_SI=1; ReqRdy_SO=0 while in DRAIN.
REQ-025 DivOutVld_SI outside WAIT/DRAIN SHALL be ignored; DivOutRdy_SO=0 in IDLE, PREP, ISSUE, RESP.
REQ-026 Divider responses SHALL NOT be reordered or duplicated; at most one operation is outstanding.

Reset
REQ-027 Rst_RI=1 at a clock edge SHALL force state DRAIN, clearing all data and tag registers to 0.
REQ-028 During reset SHALL drive ReqRdy_SO=0, RspVld_SO=0, DivInVld_SO=0, DivOutRdy_SO=0, and all data outputs 0.
REQ-029 Reset mid-operation SHALL abandon the operation; DRAIN resynchronises the divider, whose IDLE and FINISH states both present DivOutVld_SI=1.
REQ-030 Reset SHALL take priority over Flush_SI and all handshakes.

Verification
REQ-031 DIVU A=100, B=7, tag=3 -> DivOpB=0xE0000000, Shift=29, one-cycle DivInVld; then RspRes=14, RspTag=3, RspVld at accept+34.
REQ-032 DIV A=-100, B=7 -> Shift=28, DivOpB=0x70000000, DivOpBSign=0; result 0xFFFFFFF2 passed through unmodified.
REQ-033 REMU A=0x1234, B=0 -> Shift=31, DivOpBIsZero=1, DivOpB=0; RspRes=0x1234.
REQ-034 Flush in WAIT at accept+6 -> DRAIN, no RspVld; ReqRdy returns 1 the cycle after the divider's DivOutVld.
REQ-035 RspRdy held 0 for 3 cycles in RESP -> RspVld, RspRes and RspTag constant; the 4th cycle handshake returns to IDLE.
REQ-036 Rst_RI pulsed 1 cycle in WAIT while the divider is mid-divide -> DRAIN with DivOutRdy=1, IDLE after divider FINISH; the next DIVU 100/7 returns 14.
